serial_adder: RTL
=================

# serial_adder

Parametrised bit-serial ripple adder built around a single full-adder cell. It reuses one carry flip-flop across `WIDTH` clock cycles instead of instantiating `WIDTH` cells, and reports completion through a start/busy/done handshake. It sits beside the clock/counter logic on the Spartan-3 board and serves as the arithmetic primitive for multi-bit time and counter updates where area matters more than latency.

## Interface
Parameters:
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.

Ports:
- `CLK`  in  1  — single system clock; all state changes on the rising edge.
- `RST`  in  1  — reset, asynchronous and active-high.
- `START`  in  1  — request a new operation; sampled only in IDLE.
- `A`  in  `WIDTH`  — operand A; captured on the accepting edge.
- `B`  in  `WIDTH`  — operand B; captured on the accepting edge.
- `C_in`  in  1  — carry-in; captured on the accepting edge.
- `SUB`  in  1  — subtract select; present only when `SERIAL_ADDER_SUB_EN` is defined.
- `BUSY`  out  1  — high while an operation is in progress.
- `DONE`  out  1  — one-cycle pulse when `S`, `C_out` and `OVF` update.
- `S`  out  `WIDTH`  — registered sum; holds its value until the next completion.
- `C_out`  out  1  — carry out of the MSB.
- `OVF`  out  1  — two's-complement overflow: carry into the MSB XOR `C_out`.

## Operation
- FSM states:
  - IDLE: `BUSY`=0. On `START`=1, capture `A`, `B` and `C_in` into shift/carry registers, clear the bit counter, go to RUN.
  - RUN: `BUSY`=1. Each cycle:
    - Add bit 0 of the A and B shift registers and the carry register with the full-adder equations `s = a^b^c`, `co = ab|ac|bc`.
    - Shift `s` into the MSB of the sum shift register; shift the operand registers right; store `co`; increment the counter.
    - After processing bit `WIDTH-1`, load `S`, `C_out` and `OVF` from the final values, pulse `DONE`, and return to IDLE.
- Bit counter is `$clog2(WIDTH)` bits wide, counts 0..`WIDTH-1`, and never wraps inside an operation.
- `START` in RUN is ignored, with no queuing. The operands in flight are unaffected by any input change after capture.
- `S`, `C_out` and `OVF` change only on the completion edge. Between operations they hold the last result.
- Overflow: `OVF` = carry into bit `WIDTH-1` XOR carry out of bit `WIDTH-1`. It is evaluated on the last RUN cycle.

## Timing
- Reset values: `BUSY`=0, `DONE`=0, `S`=0, `C_out`=0, `OVF`=0; state IDLE; internal registers zero.
- `START` accepted at edge k: `BUSY` rises after edge k.
- Edge k+`WIDTH`: result registered, `BUSY`=0, `DONE`=1 for exactly one cycle.
- Latency from accepting edge to result is `WIDTH` cycles.
- Earliest next accept is edge k+`WIDTH`+1, which is also the cycle `DONE` is high. Maximum throughput is one operation per `WIDTH`+1 cycles.
- `START` held high continuously gives back-to-back operations at that rate.
- `RST` asserted mid-operation:
  - Aborts immediately to IDLE with all outputs at reset values.
  - No `DONE` pulse.
  - The previous result is lost.
- `RST` and `START` high together: reset wins.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - `SUB` port exists.
  - With `SUB`=1 on the accepting edge, the block captures ~`B` in place of `B` and forces the carry to 1 in place of `C_in`, computing `A`−`B`.
  - `C_out`=1 means no borrow; `OVF` is signed subtract overflow.
  - `SUB`=0 behaves as the plain adder.
- Not defined: no `SUB` port, no inversion logic, add-only behaviour.

## Test plan
- `WIDTH`=8, `A`=8'h5A, `B`=8'h3C, `C_in`=0, `START` pulse -> after 8 cycles `S`=8'h96, `C_out`=0, `OVF`=1; `DONE` high for exactly one cycle; `BUSY` high for 8 cycles.
- `A`=8'hFF, `B`=8'h01, `C_in`=0 -> `S`=8'h00, `C_out`=1, `OVF`=0. Then `A`=8'h00, `B`=8'h00, `C_in`=1 -> `S`=8'h01, `C_out`=0.
- `START` pulsed again 3 cycles into an operation with different operands -> ignored; the first result is unchanged; `DONE` pulses once.
- `RST` asserted 4 cycles into an operation -> `BUSY`=0, `S`=0, no `DONE`. A following `START` with `A`=8'h01, `B`=8'h01 -> `S`=8'h02.
- `START` held high, 3 operations -> `DONE` pulses 9 cycles apart; each `S` is correct.
- With `SERIAL_ADDER_SUB_EN`, `SUB`=1, `A`=8'h10, `B`=8'h20 -> `S`=8'hF0, `C_out`=0, `OVF`=0. With `A`=8'h80, `B`=8'h01 -> `S`=8'h7F, `C_out`=1, `OVF`=1.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// The SUB signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic             SUB;
`endif
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             OVF;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output START, A, B, C_in, SUB, input BUSY, DONE, S, C_out, OVF);
  modport slave  (input START, A, B, C_in, SUB, output BUSY, DONE, S, C_out, OVF);
`else
  modport master (output START, A, B, C_in, input BUSY, DONE, S, C_out, OVF);
  modport slave  (input START, A, B, C_in, output BUSY, DONE, S, C_out, OVF);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and one carry flop reused over WIDTH cycles.
// Optional subtract mode (SUB port) is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           CLK,
  input logic           RST,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             bit_s;
  logic             bit_c;

  // Operand B and carry-in as captured on the accepting edge.
  always_comb begin
    b_in = bus.B;
    c_in = bus.C_in;
`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as A + ~B + 1.
    if (bus.SUB) begin
      b_in = ~bus.B;
      c_in = 1'b1;
    end else begin
      b_in = bus.B;
      c_in = bus.C_in;
    end
`endif
  end

  // Next-state, datapath and output logic of the serial FSM.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    bit_s   = fa_sum(a_q[0], b_q[0], carry_q);
    bit_c   = fa_carry(a_q[0], b_q[0], carry_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          a_d     = bus.A;
          b_d     = b_in;
          carry_d = c_in;
          sum_d   = {WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        sum_d   = {bit_s, sum_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = bit_c;
        if (cnt_q == CNT_LAST) begin
          // carry_q here is the carry into the MSB, so it feeds overflow directly.
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          s_d     = {bit_s, sum_q[WIDTH-1:1]};
          cout_d  = bit_c;
          ovf_d   = carry_q ^ bit_c;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_RUN;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      s_q     <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
  assign bus.S     = s_q;
  assign bus.C_out = cout_q;
  assign bus.OVF   = ovf_q;

endmodule
